// File: rtl/spi_master_regs.sv
// Register-backed SPI master: control/status/data words for an AXI-lite slave and
// one full-duplex, MSB-first SPI transfer per data-register write.
module spi_master_regs #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic        FCLK_CLK0,
    input  logic        RST_N,
    input  logic [31:0] i_data_to_registers,
    input  logic        i_wr_controll_reg,
    input  logic        i_wr_data_reg,
    output logic [31:0] o_controll_reg,
    output logic [31:0] o_status_reg,
    output logic [31:0] o_data_reg,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);
    localparam int EDGE_W = 7;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, state_next;

    logic                  ctrl_en, ctrl_cpol, ctrl_cpha;
    logic [DIV_WIDTH-1:0]  ctrl_div;
    logic                  cpol_snap, cpha_snap;
    logic [DIV_WIDTH-1:0]  div_snap, div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx, rx, data_q, tx_load;
    logic [DATA_WIDTH:0]   rx_ext;
    logic                  sclk_q, mosi_q, cs_n_q, done, overrun;

    // Control value as it will be after this edge: a simultaneous control write
    // is seen by the start check and the snapshot.
    logic                 en_new, cpol_new, cpha_new;
    logic [DIV_WIDTH-1:0] div_new;
    logic busy, start, abort, boundary, shift_last, edge_fire, complete, sample_edge;

    assign en_new   = i_wr_controll_reg ? i_data_to_registers[0] : ctrl_en;
    assign cpol_new = i_wr_controll_reg ? i_data_to_registers[1] : ctrl_cpol;
    assign cpha_new = i_wr_controll_reg ? i_data_to_registers[2] : ctrl_cpha;
    assign div_new  = i_wr_controll_reg ? i_data_to_registers[8 +: DIV_WIDTH] : ctrl_div;

    assign busy        = (state != IDLE);
    assign start       = i_wr_data_reg && en_new && !busy;
    assign abort       = i_wr_controll_reg && !i_data_to_registers[0] && busy;
    assign boundary    = (div_cnt == '0);
    assign shift_last  = (edge_cnt == LAST_EDGE);
    assign edge_fire   = boundary && !abort &&
                         ((state == SETUP) || (state == SHIFT && !shift_last));
    assign complete    = boundary && !abort && (state == HOLD);
    // Edge index 0 is the leading edge; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_edge = ~edge_cnt[0] ^ cpha_snap;
    assign rx_ext      = {rx, spi_miso};
    assign tx_load     = i_data_to_registers[DATA_WIDTH-1:0];

    always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (abort) state_next = IDLE;
                     else if (boundary) state_next = SHIFT;
            SHIFT:   if (abort) state_next = IDLE;
                     else if (boundary && shift_last) state_next = HOLD;
            HOLD:    if (abort || boundary) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_en   <= 1'b0;
            ctrl_cpol <= 1'b0;
            ctrl_cpha <= 1'b0;
            ctrl_div  <= '0;
            cpol_snap <= 1'b0;
            cpha_snap <= 1'b0;
            div_snap  <= '0;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx        <= '0;
            rx        <= '0;
            data_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (i_wr_controll_reg) begin
                ctrl_en   <= i_data_to_registers[0];
                ctrl_cpol <= i_data_to_registers[1];
                ctrl_cpha <= i_data_to_registers[2];
                ctrl_div  <= i_data_to_registers[8 +: DIV_WIDTH];
                overrun   <= 1'b0;
            end
            if (i_wr_data_reg && busy) overrun <= 1'b1;

            if (start) begin
                cpol_snap <= cpol_new;
                cpha_snap <= cpha_new;
                div_snap  <= div_new;
                div_cnt   <= div_new;
                edge_cnt  <= '0;
                rx        <= '0;
                done      <= 1'b0;
                cs_n_q    <= 1'b0;
                sclk_q    <= cpol_new;
                // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on that edge.
                if (!cpha_new) begin
                    mosi_q <= tx_load[DATA_WIDTH-1];
                    tx     <= tx_load << 1;
                end else begin
                    tx     <= tx_load;
                end
            end else if (!busy || abort || complete) begin
                sclk_q <= cpol_new;
                cs_n_q <= 1'b1;
                if (complete) begin
                    done   <= 1'b1;
                    data_q <= rx;
                end
            end else begin
                div_cnt <= boundary ? div_snap : div_cnt - 1'b1;
                if (edge_fire) begin
                    sclk_q   <= ~sclk_q;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (sample_edge) begin
                        rx <= rx_ext[DATA_WIDTH-1:0];
                    end else begin
                        mosi_q <= tx[DATA_WIDTH-1];
                        tx     <= tx << 1;
                    end
                end
            end
        end
    end

    always_comb begin
        o_controll_reg                   = '0;
        o_controll_reg[0]                = ctrl_en;
        o_controll_reg[1]                = ctrl_cpol;
        o_controll_reg[2]                = ctrl_cpha;
        o_controll_reg[8 +: DIV_WIDTH]   = ctrl_div;
    end

    assign o_status_reg = {29'b0, overrun, done, busy};
    assign o_data_reg   = 32'(data_q);
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_regs.sv
// Directed bench for spi_master_regs: modes 0/3, overrun, disabled write, abort,
// max divider, async reset mid-transfer and simultaneous strobes.
module tb_spi_master_regs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wdata;
    logic        wr_ctrl, wr_data;
    logic [31:0] ctrl_rb, status_rb, data_rb;
    logic        sclk, mosi, miso, cs_n;
    logic        loop_en, miso_drv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_drv;

    spi_master_regs #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
        .FCLK_CLK0(clk),
        .RST_N(rst_n),
        .i_data_to_registers(wdata),
        .i_wr_controll_reg(wr_ctrl),
        .i_wr_data_reg(wr_data),
        .o_controll_reg(ctrl_rb),
        .o_status_reg(status_rb),
        .o_data_reg(data_rb),
        .spi_sclk(sclk),
        .spi_mosi(mosi),
        .spi_miso(miso),
        .spi_cs_n(cs_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic wc, input logic wd, input logic [31:0] d);
        wr_ctrl = wc;
        wr_data = wd;
        wdata   = d;
        tick();
        wr_ctrl = 1'b0;
        wr_data = 1'b0;
    endtask

    // Follows a running transfer until BUSY drops; drives MISO on each falling SCLK.
    task automatic monitor_xfer(input logic [7:0] miso_pat, output int busy_cyc,
                                output int rises, output logic [7:0] mosi_cap,
                                output int half);
        logic prev;
        int   k, t_first, t_second, bit_idx;
        prev = sclk; busy_cyc = 0; rises = 0; mosi_cap = '0;
        k = 0; t_first = -1; t_second = -1; bit_idx = 7;
        while (status_rb[0] && k < 6000) begin
            busy_cyc++;
            tick();
            k++;
            if (sclk !== prev) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
                if (sclk) begin
                    rises++;
                    mosi_cap = {mosi_cap[6:0], mosi};
                end else if (bit_idx >= 0) begin
                    miso_drv = miso_pat[bit_idx];
                    bit_idx--;
                end
            end
            prev = sclk;
        end
        half = t_second - t_first;
        if (k >= 6000) check("xfer_timeout", 32'(k), 32'd0);
    endtask

    int         busy_cyc, rises, half;
    logic [7:0] mosi_cap;

    initial begin
        rst_n = 1'b0; wdata = '0; wr_ctrl = 1'b0; wr_data = 1'b0;
        loop_en = 1'b1; miso_drv = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", ctrl_rb, 32'h0);
        check("rst_status", status_rb, 32'h0);
        check("rst_data", data_rb, 32'h0);
        check("rst_cs_n", 32'(cs_n), 32'h1);
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_mosi", 32'(mosi), 32'h0);
        rst_n = 1'b1;
        tick();

        // Disabled write
        pulse(1'b1, 1'b0, 32'h0);
        pulse(1'b0, 1'b1, 32'h55);
        check("dis_cs_n", 32'(cs_n), 32'h1);
        repeat (5) tick();
        check("dis_cs_n_later", 32'(cs_n), 32'h1);
        check("dis_status", status_rb, 32'h0);
        check("dis_data", data_rb, 32'h0);

        // Mode 0 loopback
        pulse(1'b1, 1'b0, 32'h1);
        check("m0_idle_sclk", 32'(sclk), 32'h0);
        pulse(1'b0, 1'b1, 32'hA5);
        check("m0_cs_n", 32'(cs_n), 32'h0);
        check("m0_status_busy", status_rb, 32'h1);
        check("m0_mosi_msb", 32'(mosi), 32'h1);
        monitor_xfer(8'h00, busy_cyc, rises, mosi_cap, half);
        check("m0_busy_cycles", 32'(busy_cyc), 32'd18);
        check("m0_rises", 32'(rises), 32'd8);
        check("m0_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("m0_half", 32'(half), 32'd1);
        check("m0_data", data_rb, 32'hA5);
        check("m0_status_done", status_rb, 32'h2);
        check("m0_cs_n_end", 32'(cs_n), 32'h1);

        // Mode 3, DIV=3, MISO driven externally
        loop_en = 1'b0;
        pulse(1'b1, 1'b0, 32'h307);
        check("m3_ctrl", ctrl_rb, 32'h307);
        check("m3_idle_sclk", 32'(sclk), 32'h1);
        pulse(1'b0, 1'b1, 32'h96);
        monitor_xfer(8'h3C, busy_cyc, rises, mosi_cap, half);
        check("m3_busy_cycles", 32'(busy_cyc), 32'd72);
        check("m3_half", 32'(half), 32'd4);
        check("m3_mosi_bits", 32'(mosi_cap), 32'h96);
        check("m3_data", data_rb, 32'h3C);
        check("m3_status", status_rb, 32'h2);
        check("m3_sclk_end", 32'(sclk), 32'h1);

        // Overrun
        loop_en = 1'b1;
        pulse(1'b1, 1'b0, 32'h1);
        pulse(1'b0, 1'b1, 32'h11);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 32'h22);
        check("ovr_status_mid", status_rb, 32'h5);
        monitor_xfer(8'h00, busy_cyc, rises, mosi_cap, half);
        check("ovr_data", data_rb, 32'h11);
        check("ovr_status_end", status_rb, 32'h6);
        pulse(1'b1, 1'b0, 32'h1);
        check("ovr_cleared", status_rb, 32'h2);

        // Abort
        pulse(1'b1, 1'b0, 32'h301);
        pulse(1'b0, 1'b1, 32'hFF);
        repeat (20) tick();
        check("abt_busy_before", status_rb, 32'h1);
        pulse(1'b1, 1'b0, 32'h0);
        check("abt_cs_n", 32'(cs_n), 32'h1);
        check("abt_status", status_rb, 32'h0);
        check("abt_data", data_rb, 32'h11);
        check("abt_sclk", 32'(sclk), 32'h0);

        // Maximum divider
        pulse(1'b1, 1'b0, 32'hFF01);
        pulse(1'b0, 1'b1, 32'h5A);
        monitor_xfer(8'h00, busy_cyc, rises, mosi_cap, half);
        check("max_busy_cycles", 32'(busy_cyc), 32'd4608);
        check("max_half", 32'(half), 32'd256);
        check("max_data", data_rb, 32'h5A);

        // Asynchronous reset mid-transfer
        pulse(1'b1, 1'b0, 32'h301);
        pulse(1'b0, 1'b1, 32'hA5);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(cs_n), 32'h1);
        check("arst_ctrl", ctrl_rb, 32'h0);
        check("arst_status", status_rb, 32'h0);
        check("arst_data", data_rb, 32'h0);
        check("arst_sclk", 32'(sclk), 32'h0);
        rst_n = 1'b1;
        tick();

        // Simultaneous control and data strobes: EN=1, CPHA=1 arrives with the start
        pulse(1'b1, 1'b1, 32'h05);
        check("sim_ctrl", ctrl_rb, 32'h5);
        check("sim_cs_n", 32'(cs_n), 32'h0);
        check("sim_status", status_rb, 32'h1);
        monitor_xfer(8'h00, busy_cyc, rises, mosi_cap, half);
        check("sim_busy_cycles", 32'(busy_cyc), 32'd18);
        check("sim_data", data_rb, 32'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
